ultrasonic_ranger: RTL and testbench

Measurement sequencer for the ultrasound range finder. It consumes the 20 Hz divided clock from the clock-generation stage as its measurement-rate tick, fires a 10 µs trigger pulse at the sensor, times the returned echo pulse in system-clock cycles, and outputs the distance in whole centimetres with a one-cycle valid strobe. It sits between the clock-generation stage and the 7-segment display driver, which latches `DIST_CM` on `VALID`.

---
 rtl/ranger_pkg.sv | 33 +++
 rtl/ultrasonic_ranger_if.sv | 26 ++
 rtl/sync_edge.sv | 40 ++++
 rtl/ultrasonic_ranger.sv | 133 +++++++++++++
 tb/tb_ultrasonic_ranger.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ranger_pkg.sv
// Shared types and defaults for the ultrasonic range finder.
// Provides the sequencer state encoding, default parameter values and the
// helper that sizes the shared cycle counter.
package ranger_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_e;

  localparam int TRIG_CYCLES_DEF      = 500;        // 10 us at 50 MHz
  localparam int CYC_PER_CM_DEF       = 2900;       // 58 us at 50 MHz
  localparam int MAX_CM_DEF           = 400;
  localparam int ECHO_WAIT_CYCLES_DEF = 1_500_000;  // 30 ms at 50 MHz
  localparam int DW_DEF               = 9;

  localparam int CNT_W_DEF = $clog2(ECHO_WAIT_CYCLES_DEF);

  // The single counter has to reach the largest of the three terminal
  // values minus one, so its width follows the largest limit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor and result signals of the range finder.
// master: the ranger (drives TRIG and the result); slave: sensor/display side
// (drives TICK and ECHO, observes the rest).
interface ultrasonic_ranger_if #(
  parameter int DW = 9
) ();

  logic          TICK;
  logic          ECHO;
  logic          TRIG;
  logic [DW-1:0] DIST_CM;
  logic          VALID;
  logic          TIMEOUT;
  logic          BUSY;

  modport master (
    input  TICK, ECHO,
    output TRIG, DIST_CM, VALID, TIMEOUT, BUSY
  );

  modport slave (
    output TICK, ECHO,
    input  TRIG, DIST_CM, VALID, TIMEOUT, BUSY
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// Ports: clk, rst_n (sync, active-low), async_in; rise/fall are one-cycle
// pulses, 3 clocks after the input is first sampled at its new level.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic s1, s2, prev;
  logic v1, v2;    // tracks when s2 carries a real sample after reset
  logic armed;     // set once a genuine low has been seen

  // After reset the flops read 0, so an input already high would look like
  // a rise. Edges are only reported after s2 has shown a real low level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      armed <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= async_in;
      s2    <= s1;
      prev  <= s2;
      v1    <= 1'b1;
      v2    <= v1;
      armed <= armed | (v2 & ~s2);
      rise  <= armed & s2 & ~prev;
      fall  <= armed & ~s2 & prev;
    end
  end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Measurement sequencer: on each TICK rise, fires TRIG, times the ECHO pulse
// and reports whole centimetres with a one-cycle VALID strobe.
// Ports: CLK, RST_N (sync, active-low), rng (master: TICK/ECHO in;
// TRIG, DIST_CM, VALID, TIMEOUT, BUSY out).
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int TRIG_CYCLES      = TRIG_CYCLES_DEF,
  parameter int CYC_PER_CM       = CYC_PER_CM_DEF,
  parameter int MAX_CM           = MAX_CM_DEF,
  parameter int ECHO_WAIT_CYCLES = ECHO_WAIT_CYCLES_DEF,
  parameter int DW               = DW_DEF
) (
  input  logic                CLK,
  input  logic                RST_N,
  ultrasonic_ranger_if.master rng
);

  localparam int CW = cnt_width(ECHO_WAIT_CYCLES, CYC_PER_CM, TRIG_CYCLES);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_TRIG    = TRIG;
  localparam logic [2:0] ST_WAIT    = WAIT_ECHO;
  localparam logic [2:0] ST_MEASURE = MEASURE;
  localparam logic [2:0] ST_DONE    = DONE;

  logic [2:0]    state;
  logic [CW-1:0] cnt;       // shared: trigger timer, echo wait, cm sub-counter
  logic [DW-1:0] cm;
  logic [DW-1:0] dist_q;
  logic          timeout_q;

  logic tick_rise, tick_fall_unused;
  logic echo_rise, echo_fall;

  logic          wrap;
  logic [DW-1:0] cm_next;

  sync_edge u_tick_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .async_in (rng.TICK),
    .rise     (tick_rise),
    .fall     (tick_fall_unused)
  );

  sync_edge u_echo_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .async_in (rng.ECHO),
    .rise     (echo_rise),
    .fall     (echo_fall)
  );

  // The cycle in which the sub-counter wraps is itself a counted echo cycle,
  // so a fall in that cycle reports the incremented value.
  assign wrap    = (cnt == CW'(CYC_PER_CM - 1));
  assign cm_next = wrap ? cm + DW'(1) : cm;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cm        <= '0;
      dist_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick_rise) begin
            state <= ST_TRIG;
            cnt   <= '0;
          end
        end

        ST_TRIG: begin
          if (cnt == CW'(TRIG_CYCLES - 1)) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_WAIT: begin
          if (echo_rise) begin
            state <= ST_MEASURE;
            cnt   <= '0;
            cm    <= '0;
          end else if (cnt == CW'(ECHO_WAIT_CYCLES - 1)) begin
            state     <= ST_DONE;
            dist_q    <= DW'(MAX_CM);
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_MEASURE: begin
          if (wrap && (cm_next == DW'(MAX_CM))) begin
            // Echo too long: clamp and flag, ignore the eventual fall.
            state     <= ST_DONE;
            dist_q    <= DW'(MAX_CM);
            timeout_q <= 1'b1;
          end else if (echo_fall) begin
            state     <= ST_DONE;
            dist_q    <= cm_next;
            timeout_q <= 1'b0;
          end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            cm  <= cm_next;
          end
        end

        ST_DONE: begin
          // Result registers were loaded on entry; VALID is this state.
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rng.TRIG    = (state == ST_TRIG);
  assign rng.BUSY    = (state != ST_IDLE);
  assign rng.VALID   = (state == ST_DONE);
  assign rng.DIST_CM = dist_q;
  assign rng.TIMEOUT = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger with scaled-down timing parameters.
module tb_ultrasonic_ranger;

  localparam int TRIG_C = 20;
  localparam int CPC    = 29;
  localparam int MAXC   = 40;
  localparam int EW     = 3000;
  localparam int DW     = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ultrasonic_ranger_if #(.DW(DW)) rif ();

  ultrasonic_ranger #(
    .TRIG_CYCLES      (TRIG_C),
    .CYC_PER_CM       (CPC),
    .MAX_CM           (MAXC),
    .ECHO_WAIT_CYCLES (EW),
    .DW               (DW)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .rng   (rif)
  );

  typedef struct {
    int cm;
    int to;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  res_t exp_q[$];
  res_t r;
  int   exp_dist = 0;
  int   exp_to = 0;
  int   valid_cnt = 0;
  int   last_valid_cyc = 0;
  int   pushes = 0;
  int   wait_entry_cyc = 0;
  int   t_e = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic int absd(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Expected result of an echo of w cycles: whole centimetres, clamped.
  function automatic res_t predict(input int w);
    res_t x;
    x.cm = w / CPC;
    x.to = 0;
    if (x.cm >= MAXC) begin
      x.cm = MAXC;
      x.to = 1;
    end
    return x;
  endfunction

  task automatic push_exp(input res_t x);
    exp_q.push_back(x);
    pushes++;
  endtask

  // Compare process: result on each VALID, hold value otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rif.VALID) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        chk("pending_result_on_valid", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          exp_dist = r.cm;
          exp_to = r.to;
        end
        chk("valid_dist", int'(rif.DIST_CM), exp_dist);
        chk("valid_timeout", int'(rif.TIMEOUT), exp_to);
      end else begin
        chk("hold_dist", int'(rif.DIST_CM), exp_dist);
        chk("hold_timeout", int'(rif.TIMEOUT), exp_to);
      end
      chk("trig_implies_busy", int'(rif.TRIG & ~rif.BUSY), 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    int v0;
    v0 = valid_cnt;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (valid_cnt != v0) break;
    end
    @(negedge clk);
    chk("valid_arrived", valid_cnt - v0, 1);
  endtask

  // TICK rise, then check trigger delay and width; ends at WAIT_ECHO entry.
  task automatic start_meas();
    int t0;
    int n;
    rif.TICK = 1'b0;
    cycles(4);
    rif.TICK = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rif.TRIG) break;
    end
    chk("tick_to_trig", cyc - t0, 4);
    chk("busy_with_trig", int'(rif.BUSY), 1);
    n = 0;
    while (rif.TRIG && n < TRIG_C + 50) begin
      n++;
      @(negedge clk);
    end
    chk("trig_width", n, TRIG_C);
    wait_entry_cyc = cyc;
  endtask

  task automatic echo_meas(input int w, input int lit_cm);
    start_meas();
    cycles(3);
    push_exp(predict(w));
    rif.ECHO = 1'b1;
    t_e = cyc;
    cycles(w);
    rif.ECHO = 1'b0;
    wait_valid(200);
    chk("echo_latency_window", int'(absd(last_valid_cyc - t_e - (w + 4)) <= 2), 1);
    chk("dist_literal", int'(rif.DIST_CM), lit_cm);
    chk("timeout_literal", int'(rif.TIMEOUT), 0);
  endtask

  initial begin
    int trig_seen;
    int v0;

    rif.TICK = 1'b0;
    rif.ECHO = 1'b0;
    rst_n = 1'b0;
    cycles(5);
    chk("reset_outputs", int'({rif.TRIG, rif.VALID, rif.BUSY, rif.TIMEOUT, rif.DIST_CM}), 0);
    rst_n = 1'b1;
    trig_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      trig_seen |= int'(rif.TRIG | rif.BUSY | rif.VALID);
    end
    chk("idle_stays_quiet", trig_seen, 0);

    // TICK held high through reset release must not start a measurement.
    rst_n = 1'b0;
    rif.TICK = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    trig_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      trig_seen |= int'(rif.TRIG | rif.BUSY);
    end
    chk("tick_high_at_release_ignored", trig_seen, 0);

    // Nominal and floor-rounding measurements.
    echo_meas(580, 20);
    echo_meas(28, 0);
    echo_meas(58, 2);
    echo_meas(29, 1);

    // No echo: timeout after the full echo wait.
    start_meas();
    push_exp('{cm: MAXC, to: 1});
    wait_valid(EW + 50);
    chk("no_echo_latency_window", int'(absd(last_valid_cyc - wait_entry_cyc - EW) <= 3), 1);
    chk("no_echo_dist_literal", int'(rif.DIST_CM), 40);
    chk("no_echo_timeout_literal", int'(rif.TIMEOUT), 1);

    // Long echo: clamps while echo is still high; the late fall is ignored.
    start_meas();
    cycles(3);
    push_exp(predict(2000));
    rif.ECHO = 1'b1;
    t_e = cyc;
    wait_valid(MAXC * CPC + 100);
    chk("long_echo_latency_window", int'(absd(last_valid_cyc - t_e - (MAXC * CPC + 4)) <= 2), 1);
    chk("long_dist_literal", int'(rif.DIST_CM), 40);
    chk("long_timeout_literal", int'(rif.TIMEOUT), 1);
    cycles(2000 - (cyc - t_e));
    rif.ECHO = 1'b0;
    v0 = valid_cnt;
    cycles(100);
    chk("long_echo_no_second_valid", valid_cnt - v0, 0);
    chk("long_echo_idle_after", int'(rif.BUSY), 0);

    // Second TICK rise during MEASURE is dropped.
    start_meas();
    cycles(3);
    push_exp(predict(300));
    rif.ECHO = 1'b1;
    cycles(100);
    rif.TICK = 1'b0;
    cycles(5);
    rif.TICK = 1'b1;
    cycles(195);
    rif.ECHO = 1'b0;
    wait_valid(200);
    chk("busy_tick_dist_literal", int'(rif.DIST_CM), 10);
    v0 = valid_cnt;
    cycles(200);
    chk("busy_tick_not_queued", valid_cnt - v0, 0);
    chk("busy_tick_idle", int'(rif.BUSY), 0);

    // Reset in the middle of MEASURE.
    start_meas();
    cycles(3);
    rif.ECHO = 1'b1;
    cycles(100);
    chk("pre_reset_busy", int'(rif.BUSY), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_busy", int'(rif.BUSY), 0);
    chk("mid_reset_trig", int'(rif.TRIG), 0);
    chk("mid_reset_valid", int'(rif.VALID), 0);
    chk("mid_reset_dist", int'(rif.DIST_CM), 0);
    chk("mid_reset_timeout", int'(rif.TIMEOUT), 0);
    exp_dist = 0;
    exp_to = 0;
    rif.ECHO = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    chk("post_reset_idle", int'(rif.BUSY), 0);

    // Normal operation resumes after the reset.
    echo_meas(116, 4);

    cycles(10);
    chk("all_results_delivered", valid_cnt, pushes);
    chk("no_pending_results", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
